// File: rtl/larson_pkg.sv
`default_nettype none
// ============================================================================
// Module      : larson_pkg
// Description : Shared types and constants for the 16-LED Larson scanner.
//               Holds the sweep-mode and sequencer-state enums, the LED
//               geometry, and the active-low LED select decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package larson_pkg;

  localparam int LED_COUNT = 16;
  localparam int POS_W     = 4;

  // Sweep modes as encoded on i_cfg_mode
  typedef enum logic [1:0] {
    MODE_BOUNCE    = 2'd0,
    MODE_WRAP_UP   = 2'd1,
    MODE_WRAP_DOWN = 2'd2,
    MODE_HOLD      = 2'd3
  } mode_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DWELL = 2'd2
  } state_e;

  // Active-low one-hot select for an LED index
  function automatic logic [LED_COUNT-1:0] led_select(input logic [POS_W-1:0] pos);
    logic [LED_COUNT-1:0] one;
    one = {{(LED_COUNT-1){1'b0}}, 1'b1};
    return ~(one << pos);
  endfunction

endpackage
`default_nettype wire

// File: rtl/larson_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : larson_prescaler
// Description : Step-period counter. Counts 0..i_period while i_run is high
//               and pulses o_tick on the cycle the count equals i_period,
//               then wraps to zero. i_clear forces the count to zero and
//               masks the tick in the same cycle.
// Ports       : i_clk, i_rst (async, active-high)
//               i_clear  - zero the counter, suppress tick
//               i_run    - counting enable
//               i_period - terminal count (0 = tick every cycle)
//               o_tick   - one-cycle step strobe (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module larson_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_run,
  input  logic [PRESCALE_W-1:0] i_period,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] count_q;
  logic [PRESCALE_W-1:0] count_d;
  logic                  w_at_end;

  // Equality compare: the counter is always cleared when the period changes,
  // so it can never sit above the terminal count.
  assign w_at_end = (count_q == i_period);
  assign o_tick   = i_run & ~i_clear & w_at_end;

  always_comb begin
    count_d = count_q;
    if (i_clear || !i_run) begin
      count_d = '0;
    end else if (w_at_end) begin
      count_d = '0;
    end else begin
      count_d = count_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/larson_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : larson_scan_controller
// Description : Sequencer for the 16-LED scanner. Owns the LED position,
//               direction, sweep mode, step period and end dwell. Steps the
//               position on prescaler ticks while enabled and drives the
//               active-low one-of-16 LED select lines. Configuration is
//               loaded through a valid/ready handshake.
// Ports       : i_clk, i_rst (async, active-high)
//               i_enable                 - run / freeze
//               i_cfg_valid, o_cfg_ready - config handshake
//               i_cfg_mode/period/dwell  - config payload
//               o_position, o_direction  - current LED index and sweep dir
//               o_step                   - pulse with each new position
//               o_selection              - ~(1 << o_position)
// Revision    : 1.0 - initial release
// ============================================================================
module larson_scan_controller
  import larson_pkg::*;
#(
  parameter int PRESCALE_W     = 16,
  parameter int DWELL_W        = 4,
  parameter int DEFAULT_PERIOD = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  input  logic [1:0]            i_cfg_mode,
  input  logic [PRESCALE_W-1:0] i_cfg_period,
  input  logic [DWELL_W-1:0]    i_cfg_dwell,
  output logic [POS_W-1:0]      o_position,
  output logic                  o_direction,
  output logic                  o_step,
  output logic [LED_COUNT-1:0]  o_selection
);

  localparam logic [POS_W-1:0]      c_pos_one  = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0]      c_pos_top  = {POS_W{1'b1}};
  localparam logic [DWELL_W-1:0]    c_dwl_one  = {{(DWELL_W-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] c_def_per  = PRESCALE_W'(DEFAULT_PERIOD);

  state_e                 state_q,     state_d;
  mode_e                  mode_q,      mode_d;
  logic [POS_W-1:0]       pos_q,       pos_d;
  logic                   dir_q,       dir_d;
  logic [PRESCALE_W-1:0]  period_q,    period_d;
  logic [DWELL_W-1:0]     dwell_cfg_q, dwell_cfg_d;
  logic [DWELL_W-1:0]     dwell_cnt_q, dwell_cnt_d;
  logic                   step_q,      step_d;

  logic                   w_accept;
  logic                   w_run;
  logic                   w_clear;
  logic                   w_tick;
  logic [POS_W-1:0]       w_pos_up;
  logic [POS_W-1:0]       w_pos_dn;
  mode_e                  w_cfg_mode;

  assign w_cfg_mode = mode_e'(i_cfg_mode);
  assign o_cfg_ready = (state_q != ST_DWELL);
  assign w_accept    = i_cfg_valid & o_cfg_ready;
  assign w_run       = i_enable & ((state_q == ST_RUN) | (state_q == ST_DWELL));
  // Clearing on accept also masks the tick, so the accept cycle never steps
  assign w_clear     = w_accept | (state_q == ST_IDLE);
  assign w_pos_up    = pos_q + c_pos_one;
  assign w_pos_dn    = pos_q - c_pos_one;

  larson_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_clear),
    .i_run    (w_run),
    .i_period (period_q),
    .o_tick   (w_tick)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    period_d    = period_q;
    dwell_cfg_d = dwell_cfg_q;
    dwell_cnt_d = dwell_cnt_q;
    step_d      = 1'b0;

    if (!i_enable) begin
      // Freeze position/direction; an interrupted dwell is abandoned
      state_d     = ST_IDLE;
      dwell_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
        end

        ST_RUN: begin
          if (w_tick) begin
            step_d = 1'b1;
            case (mode_q)
              MODE_BOUNCE: begin
                if (!dir_q) begin
                  pos_d = w_pos_up;
                  if (w_pos_up == c_pos_top) dir_d = 1'b1;
                  if ((w_pos_up == c_pos_top) && (dwell_cfg_q != '0)) begin
                    state_d     = ST_DWELL;
                    dwell_cnt_d = dwell_cfg_q;
                  end
                end else begin
                  pos_d = w_pos_dn;
                  if (w_pos_dn == '0) dir_d = 1'b0;
                  if ((w_pos_dn == '0) && (dwell_cfg_q != '0)) begin
                    state_d     = ST_DWELL;
                    dwell_cnt_d = dwell_cfg_q;
                  end
                end
              end
              MODE_WRAP_UP: begin
                pos_d = w_pos_up;
                dir_d = 1'b0;
              end
              MODE_WRAP_DOWN: begin
                pos_d = w_pos_dn;
                dir_d = 1'b1;
              end
              default: begin
                // HOLD: position parked, step strobe still marks the rate
              end
            endcase
          end
        end

        ST_DWELL: begin
          if (w_tick) begin
            if (dwell_cnt_q == c_dwl_one) begin
              state_d     = ST_RUN;
              dwell_cnt_d = '0;
            end else begin
              dwell_cnt_d = dwell_cnt_q - c_dwl_one;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Config load; position is untouched because the tick is masked here
    if (w_accept) begin
      mode_d      = w_cfg_mode;
      period_d    = i_cfg_period;
      dwell_cfg_d = i_cfg_dwell;
      case (w_cfg_mode)
        MODE_WRAP_UP:   dir_d = 1'b0;
        MODE_WRAP_DOWN: dir_d = 1'b1;
        MODE_BOUNCE: begin
          // At an endpoint the only legal bounce direction is away from it
          if (pos_q == c_pos_top)  dir_d = 1'b1;
          else if (pos_q == '0)    dir_d = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_BOUNCE;
      pos_q       <= '0;
      dir_q       <= 1'b0;
      period_q    <= c_def_per;
      dwell_cfg_q <= '0;
      dwell_cnt_q <= '0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      period_q    <= period_d;
      dwell_cfg_q <= dwell_cfg_d;
      dwell_cnt_q <= dwell_cnt_d;
      step_q      <= step_d;
    end
  end

  assign o_position  = pos_q;
  assign o_direction = dir_q;
  assign o_step      = step_q;
  assign o_selection = led_select(pos_q);

endmodule
`default_nettype wire
